// File: rtl/uart_rx_os.sv
// uart_rx_os: single-clock UART receiver, 16x oversampled.
//
// Frame: start(0), 5..8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   baud_div       clk cycles per oversample tick (0 behaves as 1)
//   rx             asynchronous serial input, idles high
//   length         data bits per frame (5..8, anything else means 8)
//   parity_en      parity bit present after the data bits
//   parity_type    1: parity bit = XOR of data, 0: XNOR of data
//   stop2          two stop bits are checked
//   rx_data        received character, right-justified, upper bits 0
//   rx_valid       one-cycle pulse qualifying rx_data and error flags
//   parity_err     parity mismatch (0 when parity disabled)
//   frame_err      a stop bit sampled low
//   busy           receiver is not idle
module uart_rx_os #(
  parameter int SYNC_STAGES = 2,
  parameter int OS_RATE     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] baud_div,
  input  logic        rx,
  input  logic [3:0]  length,
  input  logic        parity_en,
  input  logic        parity_type,
  input  logic        stop2,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        parity_err,
  output logic        frame_err,
  output logic        busy
);

  localparam int OS_W = $clog2(OS_RATE);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OS_RATE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OS_RATE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_DONE, S_BREAK
  } state_t;

  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [15:0]     div_cnt_q, div_cnt_d;
  logic [OS_W-1:0] os_cnt_q, os_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            par_bad_q, par_bad_d;
  logic            frm_bad_q, frm_bad_d;
  // frame format shadows, frozen for the whole frame
  logic [3:0]      len_q, len_d;
  logic            par_en_q, par_en_d;
  logic            par_type_q, par_type_d;
  logic            stop2_q, stop2_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            parity_err_q, parity_err_d;
  logic            frame_err_q, frame_err_d;
  logic            busy_q, busy_d;

  logic        rx_s;
  logic [15:0] bd_m1;
  logic        tick, mid, last, bit_state, bit_last, exp_par;
  logic [3:0]  len_eff;
  logic [7:0]  mask;

  always_comb begin
    rx_s      = sync_q[SYNC_STAGES-1];
    bd_m1     = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;
    // >= rather than == so a lowered baud_div cannot strand the counter
    tick      = (div_cnt_q >= bd_m1);
    mid       = tick && (os_cnt_q == OS_MID);
    last      = tick && (os_cnt_q == OS_LAST);
    bit_state = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_PARITY) ||
                (state_q == S_STOP1) || (state_q == S_STOP2);
    bit_last  = ({1'b0, bit_cnt_q} == (len_q - 4'd1));
    len_eff   = (length >= 4'd5 && length <= 4'd8) ? length : 4'd8;
    mask      = 8'hFF >> (4'd8 - len_q);
    // unreceived shreg bits are cleared at frame start, so a full reduction
    // covers exactly the len received bits
    exp_par   = par_type_q ? ^shreg_q : ~(^shreg_q);

    sync_d       = {sync_q[SYNC_STAGES-2:0], rx};
    state_d      = state_q;
    div_cnt_d    = tick ? 16'd0 : div_cnt_q + 16'd1;
    os_cnt_d     = (bit_state && tick) ? os_cnt_q + 1'b1 : os_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    par_bad_d    = par_bad_q;
    frm_bad_d    = frm_bad_q;
    len_d        = len_q;
    par_en_d     = par_en_q;
    par_type_d   = par_type_q;
    stop2_d      = stop2_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d    = S_START;
          div_cnt_d  = 16'd0;   // phase-align ticks to the start edge
          os_cnt_d   = '0;
          bit_cnt_d  = 3'd0;
          shreg_d    = 8'h00;
          par_bad_d  = 1'b0;
          frm_bad_d  = 1'b0;
          len_d      = len_eff;
          par_en_d   = parity_en;
          par_type_d = parity_type;
          stop2_d    = stop2;
        end
      end
      S_START: begin
        if (mid && rx_s)  state_d = S_IDLE;   // glitch, not a real start bit
        else if (last) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (mid) shreg_d[bit_cnt_q] = rx_s;
        if (last) begin
          if (bit_last) state_d = par_en_q ? S_PARITY : S_STOP1;
          else          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      S_PARITY: begin
        if (mid)  par_bad_d = (rx_s != exp_par);
        if (last) state_d = S_STOP1;
      end
      S_STOP1: begin
        if (mid) begin
          if (!rx_s) frm_bad_d = 1'b1;
          // leave at mid-bit so a back-to-back start edge is seen from IDLE
          if (!stop2_q) state_d = S_DONE;
        end else if (last && stop2_q) begin
          state_d = S_STOP2;
        end
      end
      S_STOP2: begin
        if (mid) begin
          if (!rx_s) frm_bad_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = frm_bad_q ? S_BREAK : S_IDLE;
      S_BREAK: if (rx_s) state_d = S_IDLE;   // held-low line must not retrigger
      default: state_d = S_IDLE;
    endcase

    // outputs are loaded on entry to DONE so the pulse coincides with it
    if (state_d == S_DONE) begin
      rx_valid_d   = 1'b1;
      rx_data_d    = shreg_q & mask;
      parity_err_d = par_en_q & par_bad_q;
      frame_err_d  = frm_bad_d;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sync_q       <= '1;
      div_cnt_q    <= 16'd0;
      os_cnt_q     <= '0;
      bit_cnt_q    <= 3'd0;
      shreg_q      <= 8'h00;
      par_bad_q    <= 1'b0;
      frm_bad_q    <= 1'b0;
      len_q        <= 4'd8;
      par_en_q     <= 1'b0;
      par_type_q   <= 1'b0;
      stop2_q      <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      div_cnt_q    <= div_cnt_d;
      os_cnt_q     <= os_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      par_bad_q    <= par_bad_d;
      frm_bad_q    <= frm_bad_d;
      len_q        <= len_d;
      par_en_q     <= par_en_d;
      par_type_q   <= par_type_d;
      stop2_q      <= stop2_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed + randomized frames for uart_rx_os, scored against
// expectations computed from the frame contents that the bench itself sends.
module tb_uart_rx_os;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic        rx;
  logic [3:0]  length;
  logic        parity_en, parity_type, stop2;
  logic [7:0]  rx_data;
  logic        rx_valid, parity_err, frame_err, busy;

  uart_rx_os dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .rx(rx), .length(length),
    .parity_en(parity_en), .parity_type(parity_type), .stop2(stop2),
    .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         bd;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int n_chk = 0, n_pass = 0;
  int n_exp = 0, n_got = 0;
  int cyc = 0, stop_cyc = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int bit_clks();
    return 16 * ((baud_div == 16'd0) ? 1 : int'(baud_div));
  endfunction

  task automatic send_bit(input logic b);
    rx = b;
    repeat (bit_clks()) @(negedge clk);
  endtask

  // Sends one frame with the current configuration and queues what the
  // receiver should report for it.
  task automatic send_frame(input logic [7:0] data, input bit bad_par,
                            input bit bad_s1, input bit bad_s2, output bit fe);
    int len, ones;
    logic good_par;
    exp_t x;
    len  = (length >= 5 && length <= 8) ? int'(length) : 8;
    ones = 0;
    for (int i = 0; i < len; i++) ones += int'(data[i]);
    good_par = parity_type ? logic'(ones % 2) : logic'(1 - ones % 2);
    fe   = bad_s1 || (stop2 && bad_s2);
    x.d  = data & 8'((1 << len) - 1);
    x.pe = parity_en && bad_par;
    x.fe = fe;
    x.bd = (baud_div == 16'd0) ? 1 : int'(baud_div);
    q.push_back(x);
    n_exp++;
    send_bit(1'b0);
    for (int i = 0; i < len; i++) send_bit(data[i]);
    if (parity_en) send_bit(good_par ^ bad_par);
    if (stop2) begin
      send_bit(!bad_s1);
      stop_cyc = cyc;
      send_bit(!bad_s2);
    end else begin
      stop_cyc = cyc;
      send_bit(!bad_s1);
    end
  endtask

  task automatic cfg(input int bd, input int len, input bit pe, input bit pt, input bit s2);
    baud_div = 16'(bd); length = 4'(len); parity_en = pe; parity_type = pt; stop2 = s2;
  endtask

  // Scoreboard: every valid pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      n_got++;
      chk("pulse_1clk", prev_v, 1'b0);
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        int dt;
        e  = q.pop_front();
        dt = cyc - stop_cyc;
        chk("rx_data", rx_data, e.d);
        chk("parity_err", parity_err, e.pe);
        chk("frame_err", frame_err, e.fe);
        chk("latency", (dt >= 8 * e.bd && dt <= 8 * e.bd + 5), 1);
      end
    end
    prev_v = rst ? 1'b0 : rx_valid;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit fe;
    int g;
    rst = 1'b1; rx = 1'b1;
    cfg(4, 8, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 8N1 basic
    send_frame(8'hA5, 0, 0, 0, fe);
    send_bit(1'b1);
    chk("hold_data", rx_data, 8'hA5);

    // 5E2 good and bad parity
    cfg(4, 5, 1, 1, 1);
    send_frame(8'h13, 0, 0, 0, fe);
    send_bit(1'b1);
    send_frame(8'h13, 1, 0, 0, fe);
    send_bit(1'b1);

    // frame error followed by a held-low line
    cfg(4, 8, 0, 0, 0);
    send_frame(8'h5A, 0, 1, 0, fe);
    repeat (5 * bit_clks()) @(negedge clk);
    chk("break_busy", busy, 1);
    rx = 1'b1;
    repeat (2 * bit_clks()) @(negedge clk);
    chk("break_idle", busy, 0);
    send_frame(8'hC3, 0, 0, 0, fe);
    send_bit(1'b1);

    // glitch shorter than half a bit
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    chk("glitch_busy", busy, 1);
    for (int i = 0; i < 64 && busy; i++) @(negedge clk);
    chk("glitch_idle", busy, 0);
    repeat (2 * bit_clks()) @(negedge clk);

    // 7O1 back-to-back
    cfg(4, 7, 1, 0, 0);
    send_frame(8'h41, 0, 0, 0, fe);
    send_frame(8'h7F, 0, 0, 0, fe);
    send_bit(1'b1);

    // reset during data bit 3
    cfg(4, 8, 0, 0, 0);
    send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    rx = 1'b1;
    repeat (bit_clks() / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_data", rx_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ferr", frame_err, 0);
    repeat (12 * bit_clks()) @(negedge clk);
    send_frame(8'h3C, 0, 0, 0, fe);
    send_bit(1'b1);

    // randomized formats and errors
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      bit s2, bp, b1, b2;
      s2 = 1'($urandom_range(0, 1));
      cfg($urandom_range(0, 3), $urandom_range(4, 9), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), s2);
      d  = 8'($urandom);
      bp = ($urandom_range(0, 3) == 0);
      b1 = ($urandom_range(0, 5) == 0);
      b2 = s2 && ($urandom_range(0, 5) == 0);
      send_frame(d, bp, b1, b2, fe);
      g = fe ? $urandom_range(1, 2) : $urandom_range(0, 2);
      for (int i = 0; i < g; i++) send_bit(1'b1);
    end

    rx = 1'b1;
    repeat (3 * 16 * 4) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    chk("pulse_count", n_got, n_exp);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Single-clock UART receiver with 16x oversampling. It is the receiving end for the `uart_tx` frame format: start bit 0, 5–8 data bits LSB first, optional parity, then 1 or 2 stop bits. It runs entirely on the system `clk`, using an internal baud-tick enable instead of a derived clock, and sits beside `uart_tx` inside `uart_top`. Each received character is reported with a one-cycle valid pulse plus error flags.

Parameters:
- SYNC_STAGES, 2, number of flops in the `rx` input synchronizer (minimum 2).
- OS_RATE, 16, oversampling ticks per bit. Fixed at 16; the mid-bit sample is taken at tick 7.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- baud_div  in  16  clk cycles per oversample tick; 0 is treated as 1.
- rx  in  1  serial line; asynchronous; idles high.
- length  in  4  data bits per frame, 5..8; any other value is treated as 8.
- parity_en  in  1  1 = parity bit present after the data bits.
- parity_type  in  1  1: expected parity bit = XOR of data bits; 0: expected = XNOR of data bits.
- stop2  in  1  1 = two stop bits are checked.
- rx_data  out  8  received data, right-justified; unused upper bits are 0.
- rx_valid  out  1  one-cycle pulse; qualifies `rx_data` and the error flags.
- parity_err  out  1  valid with `rx_valid`; parity mismatch.
- frame_err  out  1  valid with `rx_valid`; a stop bit was sampled as 0.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset:
  - All outputs are 0; state = IDLE; counters are 0.
  - The synchronizer flops reset to 1 (line idle).
  - Reset asserted mid-frame aborts the frame with no `rx_valid`.
- Tick generator:
  - Counter `div_cnt` counts 0..baud_div-1 (max(baud_div,1)-1).
  - `tick` pulses for 1 clk at wrap.
  - The counter is restarted to 0 on the IDLE→START transition so that sampling is phase-aligned to the start edge.
- `length`, `parity_en`, `parity_type` and `stop2` are captured into shadow registers on the IDLE→START transition. Changes mid-frame are ignored.
- Within each bit state, `os_cnt` (0..15) advances on `tick`. The bit is sampled when `os_cnt == 7 && tick`. The state advances when `os_cnt == 15 && tick`, and `os_cnt` returns to 0.
- FSM (all transitions on `clk`, gated by `tick` where noted):
  - IDLE:
    - Synchronized `rx` == 0 → START.
  - START:
    - Mid-sample == 1 → IDLE (glitch rejected; no output).
    - Otherwise, at `os_cnt` 15 → DATA with `bit_cnt` = 0.
  - DATA:
    - Mid-sample shifts into `shreg[bit_cnt]`.
    - At `os_cnt` 15: if `bit_cnt == len-1` → PARITY (if `parity_en`) else STOP1; otherwise `bit_cnt`++.
  - PARITY:
    - Mid-sample is compared with the expected parity over the `len` received bits; `par_bad` = mismatch.
    - At `os_cnt` 15 → STOP1.
  - STOP1:
    - Mid-sample 0 sets `frm_bad`.
    - If `stop2` → STOP2 at `os_cnt` 15.
    - If not `stop2` → DONE immediately after the mid-sample. The transition does not wait for `os_cnt` 15, so a back-to-back start bit is not missed.
  - STOP2:
    - Mid-sample 0 sets `frm_bad`; → DONE after the mid-sample.
  - DONE (1 clk):
    - `rx_valid` = 1; `rx_data` = `shreg` masked to `len` bits; `parity_err` = `par_bad` (0 if `parity_en` = 0); `frame_err` = `frm_bad`.
    - → IDLE if `frm_bad` = 0, else → BREAK.
  - BREAK:
    - Wait until synchronized `rx` == 1, then → IDLE. This prevents a held-low line from retriggering.
- Latency: `rx_valid` rises 1 clk after the final stop mid-sample.
- `rx_data` and the error flags hold their values until the next DONE.
- `parity_err` and `frame_err` may both be 1 in the same frame.

Test Plan:
- Basic 8N1: baud_div=4, length=8, parity_en=0, stop2=0; send 0xA5 LSB first at 64 clk/bit → one `rx_valid` pulse, `rx_data`=0xA5, both errors 0, pulse ~1 clk after the stop-bit mid-sample.
- 5E2 framing: length=5, parity_en=1, parity_type=1, stop2=1; send 0x13 (bits 10011, parity 1) with 2 stop bits → `rx_data`=0x13, `parity_err`=0. Resend with parity bit 0 → `parity_err`=1.
- Frame error and break: 8N1, drive stop bit 0, then hold `rx` low for 5 bit times → one pulse with `frame_err`=1; no further `rx_valid` until `rx` returns high and a new frame arrives.
- Glitch rejection: pulse `rx` low for 3 ticks (12 clk) → returns to IDLE, `rx_valid` never asserts, `busy` drops within 8 ticks.
- Back-to-back: 7O1 (length=7, parity_en=1, parity_type=0), frames 0x41 then 0x7F with no idle gap → two pulses with data 0x41 and 0x7F, both `parity_err`=0.
- Reset mid-frame: assert `rst` for 1 clk during DATA bit 3 → all outputs are 0 next clk, no `rx_valid` for the aborted frame; the next full frame 0x3C is received correctly.
